// File: rtl/cmp_search_if.sv
// Probe/verdict link between the search initiator and a magnitude comparator.
// Transfer rule: a verdict is consumed on a rising edge where outReq && inRespValid; outGuess holds until then.
interface cmp_search_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] outGuess;
    logic             outReq;
    logic             inRespValid;
    logic             inGT;
    logic             inEQ;
    logic             inLT;

    modport master (
        output outGuess, outReq,
        input  inRespValid, inGT, inEQ, inLT
    );

    modport slave (
        input  outGuess, outReq,
        output inRespValid, inGT, inEQ, inLT
    );
endinterface

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: probes a GT/EQ/LT comparator with a guess and narrows
// the range [lo, hi] on each accepted verdict until EQ, empty range or a malformed verdict.
module cmp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inStart,
    cmp_search_if.master     bus,
    output logic             outBusy,
    output logic             outDone,
    output logic             outFound,
    output logic [WIDTH-1:0] outResult,
    output logic [7:0]       outSteps,
    output logic             outErr,
    output logic [1:0]       dbg_state
);
    localparam int SW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    // Bounds carry two extra bits so lo can reach 2^WIDTH and hi can reach -1 without wrapping.
    logic signed [SW-1:0] lo_q, hi_q;
    logic signed [SW-1:0] guess_s, lo_new, hi_new, mid_sum;
    logic                 accept, onehot, empty;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        bus.outReq  = 1'b0;
        outBusy     = 1'b0;
        outDone     = 1'b0;
        accept      = 1'b0;
        onehot      = 1'b0;
        guess_s     = signed'({2'b00, bus.outGuess});
        lo_new      = lo_q;
        hi_new      = hi_q;
        mid_sum     = '0;
        empty       = 1'b0;

        case ({bus.inGT, bus.inEQ, bus.inLT})
            3'b100, 3'b010, 3'b001: onehot = 1'b1;
            default:                onehot = 1'b0;
        endcase
        if (bus.inGT) lo_new = guess_s + {{(SW-1){1'b0}}, 1'b1};
        if (bus.inLT) hi_new = guess_s - {{(SW-1){1'b0}}, 1'b1};
        empty   = lo_new > hi_new;
        mid_sum = lo_new + hi_new;

        case (state)
            S_IDLE: begin
                if (inStart) state_n = S_PROBE;
            end
            S_PROBE: begin
                bus.outReq = 1'b1;
                outBusy    = 1'b1;
                accept     = bus.inRespValid;
                if (accept && (!onehot || bus.inEQ || empty)) state_n = S_DONE;
            end
            S_DONE: begin
                outDone = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q         <= '0;
            hi_q         <= '0;
            bus.outGuess <= '0;
            outFound     <= 1'b0;
            outResult    <= '0;
            outSteps     <= '0;
            outErr       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inStart) begin
                        lo_q         <= '0;
                        hi_q         <= signed'({2'b00, {WIDTH{1'b1}}});
                        bus.outGuess <= {1'b0, {(WIDTH-1){1'b1}}};
                        outSteps     <= '0;
                        outFound     <= 1'b0;
                        outErr       <= 1'b0;
                    end
                end
                S_PROBE: begin
                    if (accept) begin
                        outSteps <= outSteps + 8'd1;
                        if (!onehot) begin
                            outErr   <= 1'b1;
                            outFound <= 1'b0;
                        end else if (bus.inEQ) begin
                            outResult <= bus.outGuess;
                            outFound  <= 1'b1;
                        end else begin
                            lo_q <= lo_new;
                            hi_q <= hi_new;
                            if (!empty) bus.outGuess <= mid_sum[WIDTH:1];
                            else        outFound     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: a scripted comparator model answers probes; expected guess
// sequences are queued per search and popped as each verdict is accepted.
module tb_cmp_search_ctrl;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             inStart;
    logic             outBusy, outDone, outFound, outErr;
    logic [W-1:0]     outResult;
    logic [7:0]       outSteps;
    logic [1:0]       dbg_state;

    cmp_search_if #(.WIDTH(W)) bus ();

    cmp_search_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .inStart   (inStart),
        .bus       (bus),
        .outBusy   (outBusy),
        .outDone   (outDone),
        .outFound  (outFound),
        .outResult (outResult),
        .outSteps  (outSteps),
        .outErr    (outErr),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // responder: 0 consistent with target, 1 always LT, 2 GT and LT together, 3 no flag
    int resp_mode = 0;
    int target    = 0;
    int delay     = 0;
    int wait_cnt  = 0;

    always_comb begin
        bus.inRespValid = bus.outReq && (wait_cnt >= delay);
        bus.inGT = 1'b0;
        bus.inEQ = 1'b0;
        bus.inLT = 1'b0;
        case (resp_mode)
            0: begin
                bus.inGT = target > int'(bus.outGuess);
                bus.inEQ = target == int'(bus.outGuess);
                bus.inLT = target < int'(bus.outGuess);
            end
            1: bus.inLT = 1'b1;
            2: begin bus.inGT = 1'b1; bus.inLT = 1'b1; end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (bus.outReq && bus.inRespValid) wait_cnt <= 0;
        else if (bus.outReq)               wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    // scoreboard: expected guesses popped on each accepted probe
    logic [W-1:0] exp_q[$];
    logic         prev_wait = 1'b0;
    logic [W-1:0] prev_guess = '0;

    always @(negedge clk) begin
        if (bus.outReq && prev_wait) check("guess_hold", 32'(bus.outGuess), 32'(prev_guess));
        if (bus.outReq && bus.inRespValid) begin
            if (exp_q.size() == 0) check("unexpected_probe", 32'(bus.outGuess), 32'hFFFF);
            else                   check("probe_guess", 32'(bus.outGuess), 32'(exp_q.pop_front()));
        end
        prev_wait  = bus.outReq && !bus.inRespValid;
        prev_guess = bus.outGuess;
    end

    typedef struct {
        int           mode;
        int           tgt;
        int           dly;
        int           n;
        logic [W-1:0] g[6];
        logic         found;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        bit  done_seen;
        resp_mode = v.mode;
        target    = v.tgt;
        delay     = v.dly;
        for (int k = 0; k < v.n; k++) exp_q.push_back(v.g[k]);
        @(negedge clk);
        inStart = 1'b1;
        @(posedge clk);
        #1 inStart = 1'b0;
        @(negedge clk);
        check({tag, "_busy"},  32'(outBusy), 32'd1);
        check({tag, "_clear"}, {29'd0, outErr, outFound, outSteps != 8'd0}, 32'd0);
        lat = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 200 && !done_seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (outDone) done_seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.n * (v.dly + 1)));
        check({tag, "_found"}, 32'(outFound), 32'(v.found));
        check({tag, "_err"},   32'(outErr),   32'(v.err));
        check({tag, "_steps"}, 32'(outSteps), 32'(v.n));
        if (v.found) check({tag, "_result"}, 32'(outResult), 32'(v.tgt));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {29'd0, outDone, outBusy, bus.outReq}, 32'd0);
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{0, 11, 0, 2, '{4'd7, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[1] = '{0,  0, 0, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[2] = '{0, 15, 0, 5, '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0}, 1'b1, 1'b0};
        vecs[3] = '{1,  0, 0, 4, '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0};
        vecs[4] = '{0,  5, 3, 3, '{4'd7, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[5] = '{2,  0, 0, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1};
        vecs[6] = '{0,  9, 0, 3, '{4'd7, 4'd11, 4'd9, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[7] = '{0,  6, 1, 4, '{4'd7, 4'd3, 4'd5, 4'd6, 4'd0, 4'd0}, 1'b1, 1'b0};
        vecs[8] = '{3,  0, 2, 1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1};

        reset   = 1'b1;
        inStart = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {outBusy, outDone, outFound, outErr, bus.outReq}, 32'd0);
        check("reset_regs", {outResult, outSteps, bus.outGuess}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // reset during the second probe; a start raised mid-probe must be ignored
        resp_mode = 0;
        target    = 0;
        delay     = 0;
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd3);
        @(negedge clk);
        inStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_probe_state", 32'(dbg_state), 32'd1);
        @(negedge clk);
        check("t6_start_ignored", {22'd0, outSteps, bus.outGuess, dbg_state}, {22'd0, 8'd1, 4'd3, 2'd1} );
        inStart = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_reset_outputs", {outBusy, outDone, outFound, outErr, bus.outReq}, 32'd0);
        check("t6_reset_regs", {outResult, outSteps, bus.outGuess}, 32'd0);
        check("t6_reset_state", 32'(dbg_state), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_vec(vecs[0], "t6_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
